// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU and FSM state definitions for the multi-cycle control unit.
package ctrl_pkg;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LDR  = 3'b010;
  localparam logic [2:0] OP_STR  = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  // R-type funct field maps one-to-one onto the ALU operation code
  function automatic logic [1:0] funct_to_alu(input logic [1:0] funct);
    logic [1:0] res;
    case (funct)
      2'b00:   res = ALU_ADD;
      2'b01:   res = ALU_SUB;
      2'b10:   res = ALU_AND;
      default: res = ALU_OR;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_controller_if #(
  parameter int PC_W     = 8,
  parameter int RETIRE_W = 16
);
  logic                run;
  logic [15:0]         instr;
  logic                alu_zero;
  logic                mem_ready;
  logic [PC_W-1:0]     pc;
  logic [15:0]         ir;
  logic [2:0]          ra;
  logic [2:0]          rb;
  logic [2:0]          rd;
  logic [7:0]          imm;
  logic [1:0]          alu_op;
  logic                alu_src_imm;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                halted;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  run, instr, alu_zero, mem_ready,
    output pc, ir, ra, rb, rd, imm, alu_op, alu_src_imm,
           reg_write, mem_read, mem_write, mem_to_reg, halted, retired
  );

  modport slave (
    output run, instr, alu_zero, mem_ready,
    input  pc, ir, ra, rb, rd, imm, alu_op, alu_src_imm,
           reg_write, mem_read, mem_write, mem_to_reg, halted, retired
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational instruction field decoder: register indices, immediate, opcode class.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  op_o,
  output logic [2:0]  ra_o,
  output logic [2:0]  rb_o,
  output logic [2:0]  rd_o,
  output logic [7:0]  imm_o,
  output logic        illegal_o
);

  always_comb begin
    op_o      = ir_i[15:13];
    ra_o      = ir_i[9:7];
    rd_o      = ir_i[12:10];
    // beq/str read their second source from the rd field
    rb_o      = ((ir_i[15:13] == OP_BEQ) || (ir_i[15:13] == OP_STR)) ? ir_i[12:10] : ir_i[6:4];
    imm_o     = {{2{ir_i[5]}}, ir_i[5:0]};
    illegal_o = (ir_i[15:13] > OP_BEQ);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: owns PC, IR and retire counter; sequences
// fetch/decode/execute/memory/writeback and drives Moore datapath strobes.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 8,
  parameter int RETIRE_W = 16
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [2:0]          op;
  logic [7:0]          imm;
  logic                illegal;

  ctrl_decoder u_dec (
    .ir_i      (ir_q),
    .op_o      (op),
    .ra_o      (bus.ra),
    .rb_o      (bus.rb),
    .rd_o      (bus.rd),
    .imm_o     (imm),
    .illegal_o (illegal)
  );

  assign bus.imm     = imm;
  assign bus.pc      = pc_q;
  assign bus.ir      = ir_q;
  assign bus.retired = retired_q;
  assign bus.halted  = (state_q == HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: begin
        if (bus.run) begin
          if (int'(pc_q) >= PROG_LEN) begin
            state_d = HALT;
          end else begin
            ir_d    = bus.instr;
            pc_d    = pc_q + PC_W'(1);
            state_d = DECODE;
          end
        end
      end
      DECODE: state_d = illegal ? HALT : EXEC;
      EXEC: begin
        case (op)
          OP_LDR, OP_STR: state_d = MEM;
          OP_BEQ: begin
            // pc already points past the branch, so the offset is applied to it directly
            if (bus.alu_zero) pc_d = pc_q + PC_W'($signed(imm));
            retired_d = retired_q + RETIRE_W'(1);
            state_d   = FETCH;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        if (bus.mem_ready) begin
          if (op == OP_LDR) begin
            state_d = WB;
          end else begin
            retired_d = retired_q + RETIRE_W'(1);
            state_d   = FETCH;
          end
        end
      end
      WB: begin
        retired_d = retired_q + RETIRE_W'(1);
        state_d   = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    bus.alu_op      = ALU_ADD;
    bus.alu_src_imm = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_to_reg  = 1'b0;
    case (state_q)
      EXEC: begin
        case (op)
          OP_R:                    bus.alu_op = funct_to_alu(ir_q[1:0]);
          OP_ADDI, OP_LDR, OP_STR: bus.alu_src_imm = 1'b1;
          OP_BEQ:                  bus.alu_op = ALU_SUB;
          default:                 bus.alu_op = ALU_ADD;
        endcase
      end
      MEM: begin
        bus.mem_read  = (op == OP_LDR);
        bus.mem_write = (op == OP_STR);
      end
      WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (op == OP_LDR);
      end
      default: bus.alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an instruction-level model predicts each retirement and the final halt;
// a negedge monitor compares them against what the controller presents.
module tb_multicycle_controller;

  localparam int PC_W     = 8;
  localparam int PROG_LEN = 8;
  localparam int RETIRE_W = 16;
  localparam int MAXI     = 40;

  typedef struct {
    logic [15:0] ir;
    int          pc_after;
    bit          rw;
    bit          m2r;
    bit          mr;
    bit          mw;
    bit          src;
    logic [1:0]  alu;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;

  multicycle_controller_if #(.PC_W(PC_W), .RETIRE_W(RETIRE_W)) bus ();

  multicycle_controller #(
    .PC_W     (PC_W),
    .PROG_LEN (PROG_LEN),
    .RETIRE_W (RETIRE_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] imem [256];
  bit          zmask [256];

  assign bus.instr    = imem[bus.pc];
  assign bus.alu_zero = zmask[bus.pc];

  exp_t q[$];
  int   tests, fails;
  int   exp_count, exp_halt_pc;
  bit   exp_halt_valid;
  bit   mon_en;
  int   ready_mode;
  int   scnt;

  int         cyc, last_ret, n_ret;
  bit         halt_seen;
  int         rw_cnt, m2r_cnt, memcyc;
  bit         mr_seen, mw_seen, early, bad_hs, ready_hit, last_ready;
  logic [2:0] alu_cap;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete, tests %0d", tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (retired %0d)", nm, act, exp, bus.retired);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.alu_src_imm, bus.alu_op};
  endfunction

  // Instruction-level reference: walks the program and lists each retirement
  task automatic model(input int maxi);
    int          pc, n, op, off;
    logic [15:0] w;
    exp_t        e;
    pc = 0;
    n = 0;
    exp_halt_valid = 0;
    exp_halt_pc = 0;
    while (n < maxi) begin
      if (pc >= PROG_LEN) begin
        exp_halt_valid = 1;
        exp_halt_pc = pc;
        break;
      end
      w  = imem[pc];
      pc = (pc + 1) % 256;
      op = int'(w[15:13]);
      if (op > 4) begin
        exp_halt_valid = 1;
        exp_halt_pc = pc;
        break;
      end
      e = '{default: 0};
      e.ir = w;
      case (op)
        0: begin e.rw = 1; e.alu = w[1:0]; e.lat = 4; end
        1: begin e.rw = 1; e.src = 1; e.lat = 4; end
        2: begin e.rw = 1; e.m2r = 1; e.mr = 1; e.src = 1; e.lat = 5; end
        3: begin e.mw = 1; e.src = 1; e.lat = 4; end
        default: begin
          e.alu = 2'b01;
          e.lat = 3;
          if (zmask[pc]) begin
            off = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
            pc  = (pc + off + 256) % 256;
          end
        end
      endcase
      e.pc_after = pc;
      q.push_back(e);
      n++;
    end
    exp_count = n;
  endtask

  task automatic clr_instr();
    rw_cnt = 0; m2r_cnt = 0; memcyc = 0;
    mr_seen = 0; mw_seen = 0; early = 0; bad_hs = 0; ready_hit = 0; last_ready = 0;
    alu_cap = 3'b000;
  endtask

  task automatic finalize();
    exp_t e;
    int   xl;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL extra_retire: retired %0d with none expected", bus.retired);
    end else begin
      e = q.pop_front();
      chk("retired_count", 64'(bus.retired), 64'(n_ret + 1));
      chk("ir", 64'(bus.ir), 64'(e.ir));
      chk("pc_after", 64'(bus.pc), 64'(e.pc_after));
      chk("strobe_pattern", 64'({rw_cnt[7:0], m2r_cnt[7:0], mr_seen, mw_seen, early}),
          64'({8'(e.rw), 8'(e.m2r), e.mr, e.mw, 1'b0}));
      chk("alu_ctrl", 64'(alu_cap), 64'({e.alu, e.src}));
      xl = e.lat + ((memcyc > 0) ? memcyc - 1 : 0);
      chk("latency", 64'(cyc - last_ret), 64'(xl));
      if (e.mr || e.mw) chk("mem_handshake", 64'({bad_hs, last_ready}), 64'(2'b01));
    end
    n_ret++;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0; last_ret = 1; n_ret = 0; halt_seen = 0;
        clr_instr();
      end else if (mon_en) begin
        cyc++;
        if (int'(bus.retired) != n_ret) begin
          finalize();
          last_ret = cyc;
          clr_instr();
        end
        if (bus.halted) begin
          if (!halt_seen) begin
            halt_seen = 1;
            if (!exp_halt_valid) begin
              tests++;
              fails++;
              $display("FAIL unexpected_halt: pc %0d retired %0d", bus.pc, bus.retired);
            end else begin
              chk("halt_pc", 64'(bus.pc), 64'(exp_halt_pc));
              chk("halt_drained", 64'(q.size()), 64'd0);
              chk("halt_retired", 64'(bus.retired), 64'(exp_count));
            end
          end
          if (exp_halt_valid)
            chk("halt_idle", 64'({strobes(), bus.pc}), 64'({7'd0, 8'(exp_halt_pc)}));
        end else begin
          if ((cyc - last_ret) < 2 && strobes() != 7'd0) early = 1;
          if ((cyc - last_ret) == 2) alu_cap = {bus.alu_op, bus.alu_src_imm};
          rw_cnt  += int'(bus.reg_write);
          m2r_cnt += int'(bus.mem_to_reg);
          if (bus.mem_read || bus.mem_write) begin
            if (ready_hit) bad_hs = 1;
            memcyc++;
            mr_seen |= bus.mem_read;
            mw_seen |= bus.mem_write;
            last_ready = bus.mem_ready;
            if (bus.mem_ready) ready_hit = 1;
          end
        end
      end
    end
  end

  // Data-memory ready: tied high, random, or held low for the first three strobe cycles
  initial begin
    scnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_read || bus.mem_write) scnt++;
      else scnt = 0;
      case (ready_mode)
        0:       bus.mem_ready = 1'b1;
        1:       bus.mem_ready = 1'($urandom_range(0, 1));
        2:       bus.mem_ready = ($urandom_range(0, 3) == 0);
        3:       bus.mem_ready = (scnt >= 4);
        default: bus.mem_ready = 1'b0;
      endcase
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill_illegal();
    for (int a = 0; a < 256; a++) begin
      imem[a]  = 16'hE000;
      zmask[a] = 1'b0;
    end
  endtask

  task automatic gen_random();
    logic [15:0] w;
    int          r;
    for (int a = 0; a < 256; a++) begin
      w = 16'($urandom);
      r = $urandom_range(0, 19);
      if (r < 4 || r == 19) w[15:13] = 3'd0;
      else if (r < 7)       w[15:13] = 3'd1;
      else if (r < 10)      w[15:13] = 3'd2;
      else if (r < 13)      w[15:13] = 3'd3;
      else if (r < 18) begin
        w[15:13] = 3'd4;
        if ($urandom_range(0, 3) != 0) w[5:0] = 6'($urandom_range(0, 7)) - 6'd4;
      end else begin
        w[15:13] = 3'(5 + $urandom_range(0, 2));
      end
      imem[a]  = w;
      zmask[a] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_prog(input int maxi);
    bit done;
    q.delete();
    model(maxi);
    mon_en  = 1'b1;
    bus.run = 1'b1;
    do_reset();
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk);
      if (halt_seen || (!exp_halt_valid && n_ret >= exp_count)) done = 1;
    end
    #1;
    chk("completion", 64'(done), 64'd1);
    if (done && halt_seen) begin
      repeat (3) @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    q.delete();
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.mem_ready = 1'b1;
    ready_mode = 0;
    mon_en = 1'b0;
    tests = 0;
    fails = 0;

    // ldr r2,r1,#26; addi r3,r2,#5; add r4,r3,r2; then illegal
    fill_illegal();
    imem[0] = 16'h489A;
    imem[1] = 16'h2D05;
    imem[2] = 16'h11A0;
    run_prog(MAXI);

    // beq at pc=1 with offset +2, taken then not taken (falls onto opcode 110)
    fill_illegal();
    imem[0] = 16'h11A0;
    imem[1] = 16'h8002;
    zmask[2] = 1'b1;
    run_prog(MAXI);
    zmask[2] = 1'b0;
    imem[2]  = 16'hC000;
    run_prog(MAXI);

    // str with three not-ready cycles
    fill_illegal();
    imem[0] = 16'h6000;
    ready_mode = 3;
    run_prog(MAXI);

    // straight-line code runs off the end of the program
    for (int a = 0; a < 256; a++) imem[a] = 16'h11A1;
    ready_mode = 0;
    run_prog(MAXI);

    repeat (30) begin
      gen_random();
      ready_mode = $urandom_range(0, 2);
      run_prog(MAXI);
    end

    // run held low: no fetch, no strobes
    mon_en = 1'b0;
    bus.run = 1'b0;
    ready_mode = 0;
    do_reset();
    repeat (10) begin
      @(negedge clk);
      chk("run_low_idle", 64'({strobes(), bus.pc, bus.retired, bus.halted}), 64'd0);
    end

    // reset during a stalled ldr aborts it without writeback
    @(posedge clk);
    #1;
    fill_illegal();
    imem[0] = 16'h4000;
    ready_mode = 4;
    bus.run = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_read) seen = 1;
    end
    chk("midmem_reached", 64'(seen), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("midmem_abort", 64'({bus.reg_write, bus.mem_read, bus.pc, bus.retired}), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control unit for the 16-bit, 8-register core.
- Owns the PC and instruction register. Sequences fetch/decode/execute/memory/writeback over the instruction memory, register file, ALU and data memory.
- Decodes the 3-bit opcode ISA and drives one-hot-style control strobes per state.
- Stalls on a data-memory ready handshake and halts on an illegal opcode or a PC past the program end.

Parameters:
- PC_W, 8, PC width; instruction memory index.
- PROG_LEN, 8, number of valid instruction words; a fetch with pc >= PROG_LEN enters HALT.
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  when low, FSM holds in FETCH with no strobes
- instr  in  16  instruction memory read data for address pc (combinational)
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  data memory access complete this cycle
- pc  out  PC_W  current program counter
- ir  out  16  latched instruction
- ra  out  3  ir[9:7]
- rb  out  3  ir[12:10] for beq/str, else ir[6:4]
- rd  out  3  ir[12:10]
- imm  out  8  sign-extended ir[5:0]
- alu_op  out  2  00 add, 01 sub, 10 and, 11 or
- alu_src_imm  out  1  ALU B operand = imm
- reg_write, mem_read, mem_write, mem_to_reg  out  1 each  datapath strobes
- halted  out  1  FSM in HALT
- retired  out  RETIRE_W  instructions completed, wraps

Behaviour:
- Reset (sync, active-high): state=FETCH, pc=0, ir=0, retired=0, all strobes 0, halted=0. Reset in any state, including a MEM wait, aborts the instruction with no writeback.
- Decode: op = ir[15:13].
  - 000 R-type; funct ir[1:0] gives alu_op directly.
  - 001 addi.
  - 010 ldr: rd = mem[ra + imm].
  - 011 str: mem[ra + imm] = reg[rb].
  - 100 beq: if reg[ra] == reg[rb], pc = pc + 1 + imm.
  - 101-111 illegal.
- FETCH:
  - If !run: stay.
  - Else if pc >= PROG_LEN: go to HALT.
  - Else: ir <= instr, pc <= pc+1 (mod 2^PC_W), go to DECODE.
- DECODE: illegal op -> HALT (not retired); else -> EXEC.
- EXEC:
  - R/addi: alu_src_imm = (op==001), alu_op per type (addi add) -> WB.
  - ldr/str: alu add, alu_src_imm=1 -> MEM.
  - beq: alu_op=01. If alu_zero, pc <= pc + imm (pc already incremented; 8-bit wrap). Retire; -> FETCH.
- MEM:
  - ldr asserts mem_read; str asserts mem_write. Strobe held each cycle until mem_ready=1.
  - On ready: ldr -> WB; str retires -> FETCH.
  - mem_ready outside MEM is ignored.
- WB: reg_write=1 for one cycle; mem_to_reg=1 for ldr. Retire; -> FETCH.
- Latency with mem_ready already high: R/addi 4 cycles, ldr 5, str 4, beq 3.
- HALT:
  - Sticky until reset; halted=1, no strobes, pc frozen.
  - An illegal-opcode halt leaves pc pointing after the bad instruction.
- Strobes are Moore outputs of state+ir, all 0 in FETCH/DECODE/HALT.
- retired increments exactly once per completed instruction and wraps at 2^RETIRE_W.
- Branch offsets range -32..+31. A target beyond PROG_LEN halts at the next FETCH.
- run sampled only in FETCH; an in-flight instruction completes regardless.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams: OP_R, OP_ADDI, OP_LDR, OP_STR, OP_BEQ.
  - alu_op codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR.
  - typedef enum state_t {FETCH, DECODE, EXEC, MEM, WB, HALT}.
- One sub-module, ctrl_decoder (combinational): ir -> ra/rb/rd/imm, op class, illegal flag. FSM, PC and counter stay in the top module.

Test Plan:
- Reset then run=1, program [ldr r2,r1,#26; addi r3,r2,#5; add r4,r3,r2], mem_ready tied 1:
  - reg_write pulses in cycles 5, 9, 13; retired=3.
  - mem_read high in cycle 4 only; pc=3.
- beq with alu_zero=1 at pc=1, imm=+2 -> pc=4 after EXEC, 3 cycles total. Same with alu_zero=0 -> pc=2.
- str with mem_ready low for 3 MEM cycles -> mem_write high 4 consecutive cycles, then FETCH; retired +1, reg_write never asserted.
- Opcode 110 at pc=2 -> HALT after DECODE, halted=1, pc=3, retired unchanged. Assert reset -> FETCH, pc=0 next cycle.
- PROG_LEN=5, straight-line code -> after the 5th retire, FETCH with pc=5 enters HALT; no strobes thereafter.
- run=0 for 10 cycles after reset -> pc=0, no strobes. Reset asserted mid-MEM wait -> no reg_write, pc=0, retired=0.
